logic_op_feeder: RTL and testbench
==================================

LOGIC_OP_FEEDER -- requirements
Module: logic_op_feeder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving operand and result width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving request FIFO entries; legal values are powers of two, at least 2.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk_in  input  1  rising-edge clock for all state.
REQ-005 reset_n_in  input  1  asynchronous, active-low reset.
REQ-006 req_valid_in  input  1  request present on req_a_in, req_b_in and req_opcode_in.
REQ-007 req_ready_out  output  1  block can accept a request this cycle.
REQ-008 req_a_in, req_b_in  input  DATA_W each  operands.
REQ-009 req_opcode_in  input  2  logic-unit opcode, passed through unmodified.
REQ-010 a_out, b_out  output  DATA_W each  operands driven to the downstream combinational logic unit.
REQ-011 opcode_out  output  2  opcode driven to the logic unit.
REQ-012 result_in  input  DATA_W  combinational result returned by the logic unit.
REQ-013 rsp_valid_out  output  1  response held in result_out and rsp_seq_out.
REQ-014 rsp_ready_in  input  1  consumer accepts the response.
REQ-015 result_out  output  DATA_W  registered result.
REQ-016 rsp_seq_out  output  4  response sequence number.
REQ-017 count_out  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Accept handshake: a request SHALL be accepted on any rising edge where req_valid_in=1 and req_ready_out=1; the entry {opcode, b, a} is written at the FIFO tail.
REQ-019 Ready rule: req_ready_out SHALL equal (count_out != DEPTH); it SHALL be registered-state derived and SHALL NOT depend on rsp_ready_in or a same-cycle pop.
REQ-020 Head drive: while count_out>0, a_out, b_out and opcode_out SHALL combinationally present the FIFO head entry.
REQ-021 Idle drive: while count_out=0, a_out, b_out and opcode_out SHALL be 0.
REQ-022 Output register free: the output register is free when rsp_valid_out=0 or rsp_ready_in=1.
REQ-023 Issue: on an edge where count_out>0 and the output register is free, the block SHALL pop the head, load result_in into result_out, set rsp_valid_out=1, and load rsp_seq_out with the issue counter, which then increments.
REQ-024 Issue counter width: the issue counter SHALL be 4 bits and wrap 15->0.
REQ-025 Response retire: on an edge where rsp_valid_out=1, rsp_ready_in=1 and no pop occurs, rsp_valid_out SHALL go to 0.
REQ-026 Stall: while rsp_valid_out=1 and rsp_ready_in=0, result_out and rsp_seq_out SHALL hold, no pop SHALL occur, and the FIFO SHALL continue accepting until full.
REQ-027 Simultaneous push and pop on one edge SHALL leave count_out unchanged and preserve order.
REQ-028 A push into an empty FIFO SHALL NOT bypass to the output in the same cycle.
REQ-029 Latency: a request accepted at edge N SHALL, with an empty FIFO and a free output register, appear on rsp_valid_out after edge N+1.
REQ-030 Throughput: the block SHALL sustain one response per cycle while rsp_ready_in=1 and the FIFO is non-empty.
REQ-031 Pointers SHALL wrap modulo DEPTH; count_out SHALL never exceed DEPTH or underflow below 0.
REQ-032 Ordering: responses SHALL leave in acceptance order, with no drops and no duplicates.

Reset
REQ-033 On reset_n_in=0, the block SHALL asynchronously clear the FIFO pointers, count_out, the issue counter, rsp_valid_out, result_out and rsp_seq_out to 0.
REQ-034 Post-reset levels: req_ready_out SHALL read 1, and a_out, b_out and opcode_out SHALL read 0.
REQ-035 Reset mid-operation SHALL discard all queued and held requests; no response from before reset SHALL appear after release.
REQ-036 Reset release: the first edge with reset_n_in=1 MAY accept a request.

Verification
REQ-037 Bench stub: result_in = a_out ^ b_out for all scenarios.
REQ-038 Single request: a=4'h3, b=4'h5, op=2'b01, rsp_ready_in=1 -> after edge N+1, rsp_valid_out=1, result_out=4'h6, rsp_seq_out=0.
REQ-039 Fill to full: hold rsp_ready_in=0 and push 6 requests -> 5 accepted (4 in FIFO, 1 in output register), count_out=4, req_ready_out=0; then release rsp_ready_in -> 5 in-order responses with seq 0..4, one per cycle.
REQ-040 Streaming: rsp_ready_in=1 and req_valid_in=1 for 20 cycles with incrementing a -> count_out never exceeds 1, 20 responses, rsp_seq_out wraps 15->0 at the 17th response.
REQ-041 Random backpressure: random rsp_ready_in and req_valid_in for 1000 cycles -> scoreboard order and value match, and result_out and rsp_seq_out are stable during every stall.
REQ-042 Reset mid-operation: 3 entries queued and a response held, pulse reset_n_in low asynchronously (off-edge) -> immediately rsp_valid_out=0 and count_out=0, and no stale response after release.
REQ-043 Idle: FIFO empty -> a_out=b_out=0 and opcode_out=2'b00.

Source files
------------

// File: rtl/logic_op_feeder.sv
// logic_op_feeder: request FIFO feeding a combinational logic unit, with a registered,
// sequence-numbered response stage that stalls under consumer backpressure.
module logic_op_feeder #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic [DATA_W-1:0]        req_a_in,
    input  logic [DATA_W-1:0]        req_b_in,
    input  logic [1:0]               req_opcode_in,
    output logic [DATA_W-1:0]        a_out,
    output logic [DATA_W-1:0]        b_out,
    output logic [1:0]               opcode_out,
    input  logic [DATA_W-1:0]        result_in,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [DATA_W-1:0]        result_out,
    output logic [3:0]               rsp_seq_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = 2 * DATA_W + 2;
    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [3:0]       issue_seq;
    logic [ENT_W-1:0] head;
    logic             push, pop, out_free, empty;
    always_comb begin
        empty         = count_out == '0;
        req_ready_out = count_out != (PTR_W+1)'(DEPTH);
        push          = req_valid_in & req_ready_out;
        out_free      = !rsp_valid_out | rsp_ready_in;
        pop           = !empty & out_free;
        head          = empty ? '0 : mem[rd_ptr];
        {opcode_out, b_out, a_out} = head;
    end
    // storage carries no reset: entries are only visible through count_out
    always_ff @(posedge clk_in)
        if (push) mem[wr_ptr] <= {req_opcode_in, req_b_in, req_a_in};
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_out     <= '0;
            issue_seq     <= '0;
            rsp_valid_out <= 1'b0;
            result_out    <= '0;
            rsp_seq_out   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_out <= count_out + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (pop) begin
                result_out    <= result_in;
                rsp_seq_out   <= issue_seq;
                issue_seq     <= issue_seq + 4'd1;
                rsp_valid_out <= 1'b1;
            end else if (rsp_ready_in) begin
                rsp_valid_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_logic_op_feeder.sv
// tb_logic_op_feeder: directed vector table, hand-written corner sequences and a
// randomized backpressure run checked against an in-order queue model.
module tb_logic_op_feeder;
    localparam int DEPTH = 4;
    logic       clk_in = 1'b0;
    logic       reset_n_in = 1'b0;
    logic       req_valid_in = 1'b0;
    logic       req_ready_out;
    logic [3:0] req_a_in = '0, req_b_in = '0;
    logic [1:0] req_opcode_in = '0;
    logic [3:0] a_out, b_out;
    logic [1:0] opcode_out;
    logic [3:0] result_in;
    logic       rsp_valid_out;
    logic       rsp_ready_in = 1'b0;
    logic [3:0] result_out;
    logic [3:0] rsp_seq_out;
    logic [2:0] count_out;

    logic_op_feeder #(.DATA_W(4), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_a_in(req_a_in), .req_b_in(req_b_in), .req_opcode_in(req_opcode_in),
        .a_out(a_out), .b_out(b_out), .opcode_out(opcode_out),
        .result_in(result_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .result_out(result_out), .rsp_seq_out(rsp_seq_out), .count_out(count_out)
    );

    assign result_in = a_out ^ b_out;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] exp_res;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_resp = 0;
    logic [3:0] exp_seq = '0;
    logic [3:0] model_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, score the handshakes that the coming edge completes,
    // then verify stall stability after the edge.
    task automatic cycle(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic rr);
        logic       stall;
        logic [3:0] held_res, held_seq;
        logic [3:0] exp_res;
        req_valid_in = v; req_a_in = a; req_b_in = b; req_opcode_in = op; rsp_ready_in = rr;
        #1;
        if (rsp_valid_out && rr) begin
            chk("no_stale_rsp", model_q.size() != 0, 1);
            if (model_q.size() != 0) begin
                exp_res = model_q.pop_front();
                chk("rsp_result", result_out, exp_res);
                chk("rsp_seq", rsp_seq_out, exp_seq);
                exp_seq++;
                n_resp++;
            end
        end
        if (v && req_ready_out) model_q.push_back(a ^ b);
        stall = rsp_valid_out && !rr;
        held_res = result_out;
        held_seq = rsp_seq_out;
        @(posedge clk_in);
        #1;
        if (stall) begin
            chk("stall_valid", rsp_valid_out, 1);
            chk("stall_result", result_out, held_res);
            chk("stall_seq", rsp_seq_out, held_seq);
        end
        if (count_out > DEPTH) chk("count_bound", count_out, DEPTH);
    endtask

    task automatic do_reset();
        reset_n_in = 1'b0;
        req_valid_in = 1'b0;
        rsp_ready_in = 1'b0;
        model_q.delete();
        exp_seq = '0;
        @(posedge clk_in);
        #3;
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        vec_t vecs [6];
        int   base;
        vecs[0] = '{4'h3, 4'h5, 2'b01, 4'h6};
        vecs[1] = '{4'hF, 4'h0, 2'b10, 4'hF};
        vecs[2] = '{4'hA, 4'h5, 2'b11, 4'hF};
        vecs[3] = '{4'hC, 4'hC, 2'b00, 4'h0};
        vecs[4] = '{4'h7, 4'h2, 2'b00, 4'h5};
        vecs[5] = '{4'h9, 4'h4, 2'b10, 4'hD};

        do_reset();
        chk("rst_ready", req_ready_out, 1);
        chk("rst_count", count_out, 0);
        chk("rst_valid", rsp_valid_out, 0);
        chk("rst_result", result_out, 0);
        chk("rst_seq", rsp_seq_out, 0);
        chk("idle_a", a_out, 0);
        chk("idle_b", b_out, 0);
        chk("idle_op", opcode_out, 0);

        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b1);
            chk("vec_no_bypass", rsp_valid_out, 0);
            chk("vec_count1", count_out, 1);
            chk("vec_head_a", a_out, vecs[i].a);
            chk("vec_head_b", b_out, vecs[i].b);
            chk("vec_head_op", opcode_out, vecs[i].op);
            cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
            chk("vec_valid", rsp_valid_out, 1);
            chk("vec_result", result_out, vecs[i].exp_res);
            chk("vec_seq", rsp_seq_out, i);
            chk("vec_idle_a", a_out, 0);
            cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
            chk("vec_retire", rsp_valid_out, 0);
        end

        // fill to full under backpressure, then drain one per cycle
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 1), 4'(3 * i), 2'(i), 1'b0);
        chk("full_count", count_out, 4);
        chk("full_ready", req_ready_out, 0);
        chk("full_accepted", model_q.size(), 5);
        base = n_resp;
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", rsp_valid_out, 1);
            chk("drain_seq", rsp_seq_out, i);
            cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        end
        chk("drain_count", n_resp - base, 5);
        chk("drain_empty", rsp_valid_out, 0);

        // streaming: seq wraps 15->0 on the 17th response
        do_reset();
        base = n_resp;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'(i), 4'h5, 2'(i), 1'b1);
            if (count_out > 1) chk("stream_count", count_out, 1);
            if (n_resp - base == 16) chk("stream_wrap_seq", rsp_seq_out, 0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        chk("stream_resps", n_resp - base, 20);

        // random traffic and backpressure
        do_reset();
        base = n_resp;
        for (int i = 0; i < 1000; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom_range(0, 2) != 0));
        for (int i = 0; i < 40 && model_q.size() != 0; i++)
            cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        chk("rand_drained", model_q.size(), 0);
        cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        chk("rand_final_valid", rsp_valid_out, 0);
        chk("rand_some_resps", (n_resp - base) > 100, 1);

        // asynchronous reset with queued and held work
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'(i + 8), 4'h1, 2'b11, 1'b0);
        chk("pre_rst_count", count_out, 3);
        chk("pre_rst_valid", rsp_valid_out, 1);
        req_valid_in = 1'b0;
        #2;
        reset_n_in = 1'b0;
        #1;
        chk("async_rst_valid", rsp_valid_out, 0);
        chk("async_rst_count", count_out, 0);
        chk("async_rst_ready", req_ready_out, 1);
        chk("async_rst_a", a_out, 0);
        chk("async_rst_seq", rsp_seq_out, 0);
        model_q.delete();
        exp_seq = '0;
        #3;
        reset_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
            chk("post_rst_no_rsp", rsp_valid_out, 0);
        end
        cycle(1'b1, 4'h6, 4'h3, 2'b01, 1'b1);
        cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);
        chk("post_rst_result", result_out, 4'h5);
        chk("post_rst_seq", rsp_seq_out, 0);
        cycle(1'b0, 4'h0, 4'h0, 2'b00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
